// File: rtl/seg_value_if.sv
// seg_value_if
//   Groups the value handshake and the segment bus of seg_value_encoder.
//
//   Signals:
//     in_value   [IN_W-1:0]  binary value to display (producer -> encoder)
//     in_valid               in_value is valid       (producer -> encoder)
//     in_ready               encoder can accept       (encoder -> producer)
//     frame_tick             frame-boundary pulse from the multiplexer
//     both7seg   [13:0]      {tens pattern, ones pattern}; bit0 = seg a, 1 = lit
//     ovf                    displayed value exceeded 99
//     done                   one-cycle pulse when both7seg is updated
//
//   Handshake: a value transfers on a rising clk edge where in_valid and
//   in_ready are both high; in_value is ignored at any other edge and
//   in_valid may remain asserted while in_ready is low.
//
//   Modports: master = value producer / tick source, slave = encoder.
interface seg_value_if #(
  parameter int IN_W = 8
);
  logic [IN_W-1:0] in_value;
  logic            in_valid;
  logic            in_ready;
  logic            frame_tick;
  logic [13:0]     both7seg;
  logic            ovf;
  logic            done;

  modport master (
    output in_value, in_valid, frame_tick,
    input  in_ready, both7seg, ovf, done
  );

  modport slave (
    input  in_value, in_valid, frame_tick,
    output in_ready, both7seg, ovf, done
  );
endinterface

// File: rtl/seg_value_encoder.sv
// seg_value_encoder
//   Converts a binary value into two BCD digits with a sequential
//   shift-add-3 (double-dabble) engine, decodes both digits to seven-segment
//   patterns and drives the packed both7seg bus of the two-digit multiplexer.
//   The bus update can be deferred to the multiplexer's frame tick so a digit
//   pair never changes mid-frame.
//
//   Parameters:
//     IN_W         width of the binary input (4..8)
//     SYNC_TO_TICK 1 = commit only on frame_tick, 0 = commit immediately
//
//   Ports:
//     clk        clock, all logic on posedge
//     rst        synchronous reset, active-high
//     bus        seg_value_if.slave (in_value/in_valid/in_ready, frame_tick,
//                both7seg, ovf, done)
//     state_dbg  current FSM state (IDLE=0, CONVERT=1, DECODE=2, WAIT=3)
//
//   Optional feature macro: SEG_LEADING_ZERO_BLANK_EN
//     When defined, a zero tens digit is shown dark (unless overflow).
//
//   Timing (value accepted at edge E): conversion on edges E+1..E+IN_W,
//   patterns registered at E+IN_W+1, earliest commit at E+IN_W+2.
module seg_value_encoder #(
  parameter int IN_W         = 8,
  parameter bit SYNC_TO_TICK = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  seg_value_if.slave    bus,
  output logic [1:0]    state_dbg
);

  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DECODE  = 2'd2,
    S_WAIT    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  bin_q, bin_d;
  logic [7:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [13:0]      pat_q, pat_d;
  logic [13:0]      seg_q, seg_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             tick_eff;
  logic [7:0]       in_ext;
  logic [3:0]       ones_adj, tens_adj;
  logic [6:0]       tens_pat;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  assign tick_eff = SYNC_TO_TICK ? bus.frame_tick : 1'b1;
  assign in_ext   = 8'(bus.in_value);

  // Add-3 correction applied to each nibble before the shift.
  assign ones_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
  assign tens_adj = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];

  always_comb begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
    tens_pat = (bcd_q[7:4] == 4'd0) ? 7'h00 : seg7(bcd_q[7:4]);
`else
    tens_pat = seg7(bcd_q[7:4]);
`endif
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    pat_d      = pat_q;
    seg_d      = seg_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          bin_d      = bus.in_value;
          bcd_d      = 8'h00;
          cnt_d      = '0;
          ovf_pend_d = (in_ext > 8'd99);
          state_d    = S_CONVERT;
        end
      end
      S_CONVERT: begin
        // The bit shifted out of the tens nibble (hundreds) is dropped;
        // overflow is tracked separately by ovf_pend.
        bcd_d = {tens_adj[2:0], ones_adj, bin_q[IN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(IN_W - 1)) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ovf_pend_q) begin
          pat_d = {7'h40, 7'h40};
        end else begin
          pat_d = {tens_pat, seg7(bcd_q[3:0])};
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tick_eff) begin
          seg_d   = pat_q;
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      pat_q      <= '0;
      seg_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      pat_q      <= pat_d;
      seg_q      <= seg_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready = (state_q == S_IDLE);
  assign bus.both7seg = seg_q;
  assign bus.ovf      = ovf_q;
  assign bus.done     = done_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_seg_value_encoder.sv
module tb_seg_value_encoder;

  localparam int IN_W = 8;
  localparam int W    = 15;   // {ovf, both7seg}

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  seg_value_if #(.IN_W(IN_W)) u_if ();

  seg_value_encoder #(.IN_W(IN_W), .SYNC_TO_TICK(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (u_if.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && u_if.done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got {ovf,seg}=%h expected no commit",
                 {u_if.ovf, u_if.both7seg});
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({u_if.ovf, u_if.both7seg} !== e) begin
          bad++;
          $display("FAIL commit: got {ovf,seg}=%h expected=%h",
                   {u_if.ovf, u_if.both7seg}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns #1 after the acceptance edge.
  task automatic send(input logic [7:0] v);
    int n;
    u_if.in_value = v;
    u_if.in_valid = 1'b1;
    n = 0;
    while (!u_if.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected=1");
    end
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!u_if.done && lat < 200);
  endtask

  task automatic push(input logic ovf, input logic [13:0] seg);
    exp_q.push_back({ovf, seg});
  endtask

  task automatic run(input logic [7:0] v, input logic ovf, input logic [13:0] seg,
                     input string name);
    int lat;
    push(ovf, seg);
    send(v);
    wait_done(lat);
    check(name, 16'(lat), 16'd10);
    @(posedge clk); #1;
    check("done_one_cycle", {15'd0, u_if.done}, 16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int viol;
    logic [13:0] prev;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    u_if.in_value   = '0;
    u_if.in_valid   = 1'b0;
    u_if.frame_tick = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    check("rst_seg",   {2'b0, u_if.both7seg}, 16'h0000);
    check("rst_ovf",   {15'd0, u_if.ovf},      16'd0);
    check("rst_done",  {15'd0, u_if.done},     16'd0);
    check("rst_ready", {15'd0, u_if.in_ready}, 16'd1);

    run(8'd42, 1'b0, 14'h335B, "lat_42");
`ifdef SEG_LEADING_ZERO_BLANK_EN
    run(8'd7,  1'b0, 14'h0007, "lat_7");
    run(8'd0,  1'b0, 14'h003F, "lat_0");
`else
    run(8'd7,  1'b0, 14'h1F87, "lat_7");
    run(8'd0,  1'b0, 14'h1FBF, "lat_0");
`endif
    run(8'd150, 1'b1, 14'h2040, "lat_150");
    check("ovf_150", {15'd0, u_if.ovf}, 16'd1);
    run(8'd100, 1'b1, 14'h2040, "lat_100");
    run(8'd99,  1'b0, 14'h37EF, "lat_99");
    check("ovf_99", {15'd0, u_if.ovf}, 16'd0);
    run(8'd255, 1'b1, 14'h2040, "lat_255");
    run(8'd99,  1'b0, 14'h37EF, "lat_99b");

    // Tick gating: nothing commits while frame_tick stays low.
    u_if.frame_tick = 1'b0;
    prev = u_if.both7seg;
    push(1'b0, 14'h36ED);
    send(8'd55);
    viol = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (u_if.both7seg !== prev || u_if.in_ready !== 1'b0) viol++;
    end
    check("gate_hold", 16'(viol), 16'd0);
    u_if.frame_tick = 1'b1;
    @(posedge clk); #1;
    u_if.frame_tick = 1'b0;
    check("gate_done", {15'd0, u_if.done}, 16'd1);
    check("gate_seg",  {2'b0, u_if.both7seg}, 16'h36ED);
    u_if.frame_tick = 1'b1;
    @(posedge clk); #1;

    // Reset during conversion of 88: accepted at E, rst sampled at E+4.
    send(8'd88);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_seg",   {2'b0, u_if.both7seg}, 16'h0000);
    check("abort_ovf",   {15'd0, u_if.ovf},      16'd0);
    check("abort_ready", {15'd0, u_if.in_ready}, 16'd1);
    viol = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (u_if.done) viol++;
    end
    check("abort_no_done", 16'(viol), 16'd0);
    run(8'd12, 1'b0, 14'h035B, "lat_12");

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
